// File: rtl/onchip_ram_avmm.sv
// Parametrised on-chip RAM with an Avalon-MM slave port, post-reset zero-fill and 1/2-cycle reads.
// Define RAM_PARITY_EN to store one even-parity bit per byte lane and flag mismatches on readout.
module onchip_ram_avmm #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 14,
  parameter int DEPTH         = 10240,
  parameter int READ_LAT      = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                init_done,
  output logic                parity_err
);
  localparam int LANES = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  // state | meaning
  // INIT  | zero-filling one word per enabled cycle, all commands stalled
  // RUN   | normal operation, stalls only while clken=0
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  localparam state_t ST_RESET = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fill_cnt;
  logic              fill_we, in_range, rd_acc, wr_acc;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              s1_vld;
  logic [DATA_W-1:0] s1_data;
  logic              out_vld;
  logic [DATA_W-1:0] out_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RESET;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_INIT: if (clken && fill_cnt == LAST) state_next = ST_RUN;
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_RESET;
    endcase
  end

  always_comb begin
    fill_we     = 1'b0;
    waitrequest = ~clken;
    if (state == ST_INIT) begin
      fill_we     = clken;
      waitrequest = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     fill_cnt <= '0;
    else if (fill_we) fill_cnt <= fill_cnt + 1'b1;
  end

  // Registered so it stays low through reset even when the fill is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) init_done <= 1'b0;
    else          init_done <= (state_next == ST_RUN);
  end

  assign in_range = {1'b0, address} < DEPTH_X;
  assign wr_acc   = chipselect & ~waitrequest & write;
  assign rd_acc   = chipselect & ~waitrequest & read & ~write;
  assign rd_word  = in_range ? mem[address] : '0;

  always_ff @(posedge clk) begin
    if (fill_we) mem[fill_cnt] <= '0;
    else if (wr_acc && in_range)
      for (int i = 0; i < LANES; i++)
        if (byteenable[i]) mem[address][8*i +: 8] <= writedata[8*i +: 8];
  end

`ifdef RAM_PARITY_EN
  logic [LANES-1:0] par_mem [DEPTH];
  logic [LANES-1:0] rd_par, s1_par, out_par;

  function automatic logic [LANES-1:0] lane_par(input logic [DATA_W-1:0] d);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

  always_ff @(posedge clk) begin
    if (fill_we) par_mem[fill_cnt] <= '0;
    else if (wr_acc && in_range)
      for (int i = 0; i < LANES; i++)
        if (byteenable[i]) par_mem[address][i] <= ^writedata[8*i +: 8];
  end

  assign rd_par = in_range ? par_mem[address] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    s1_par <= '0;
    else if (clken)  s1_par <= rd_par;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else if (clken) begin
      s1_vld  <= rd_acc;
      s1_data <= rd_word;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_vld;
    logic [DATA_W-1:0] s2_data;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s2_vld  <= 1'b0;
        s2_data <= '0;
      end else if (clken) begin
        s2_vld  <= s1_vld;
        s2_data <= s1_data;
      end
    end
    assign out_vld  = s2_vld;
    assign out_data = s2_data;
`ifdef RAM_PARITY_EN
    logic [LANES-1:0] s2_par;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   s2_par <= '0;
      else if (clken) s2_par <= s1_par;
    end
    assign out_par = s2_par;
`endif
  end else begin : g_lat1
    assign out_vld  = s1_vld;
    assign out_data = s1_data;
`ifdef RAM_PARITY_EN
    assign out_par  = s1_par;
`endif
  end

  // A frozen pipeline keeps its word but must not present it as a new beat.
  assign readdatavalid = out_vld & clken;
  assign readdata      = out_data;

`ifdef RAM_PARITY_EN
  assign parity_err = readdatavalid & (|(lane_par(out_data) ^ out_par));
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// Randomised bench for onchip_ram_avmm (DEPTH=20, READ_LAT=2) against a queue/array reference model.
module tb_onchip_ram_avmm;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 20;
  localparam int READ_LAT = 2;
  localparam int LANES    = DATA_W / 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clken = 1'b1;
  logic              chipselect = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [LANES-1:0]  byteenable = '0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid, waitrequest, init_done, parity_err;

  int n_checks = 0;
  int n_errors = 0;

  onchip_ram_avmm #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .INIT_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .chipselect(chipselect), .read(read),
    .write(write), .address(address), .byteenable(byteenable), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .init_done(init_done), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word array, per-lane corruption mask, and a queue of reads in flight
  // tagged with the number of enabled edges seen since acceptance.
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [LANES-1:0]  m_bad [DEPTH];
  int                m_fill_left = DEPTH;
  bit                m_done = 1'b0;
  logic [DATA_W-1:0] q_data[$];
  int                q_age[$];
  bit                q_bad[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fill_left = DEPTH;
      m_done = 1'b0;
      q_data.delete(); q_age.delete(); q_bad.delete();
    end else if (m_fill_left > 0) begin
      if (clken) begin
        m_fill_left--;
        if (m_fill_left == 0) begin
          m_done = 1'b1;
          for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_bad[i] = '0; end
        end
      end
    end else if (clken) begin
      if (q_age.size() > 0 && q_age[0] == READ_LAT) begin
        void'(q_data.pop_front()); void'(q_age.pop_front()); void'(q_bad.pop_front());
      end
      foreach (q_age[i]) q_age[i]++;
      if (chipselect && read && !write) begin
        if (int'(address) < DEPTH) begin
          q_data.push_back(m_mem[address]); q_bad.push_back(|m_bad[address]);
        end else begin
          q_data.push_back('0); q_bad.push_back(1'b0);
        end
        q_age.push_back(1);
      end
      if (chipselect && write && int'(address) < DEPTH)
        for (int i = 0; i < LANES; i++)
          if (byteenable[i]) begin
            m_mem[address][8*i +: 8] = writedata[8*i +: 8];
            m_bad[address][i] = 1'b0;
          end
    end
  end

  always @(negedge clk) begin
    bit exp_vld, exp_wait;
    if (!reset_n) begin
      check("rst_readdatavalid", readdatavalid, 0);
      check("rst_readdata", readdata, 0);
      check("rst_init_done", init_done, 0);
      check("rst_waitrequest", waitrequest, 1);
    end else begin
      exp_wait = (m_fill_left > 0) ? 1'b1 : !clken;
      exp_vld  = clken && q_age.size() > 0 && q_age[0] == READ_LAT;
      check("waitrequest", waitrequest, exp_wait);
      check("init_done", init_done, m_done);
      check("readdatavalid", readdatavalid, exp_vld);
      if (exp_vld) check("readdata", readdata, q_data[0]);
      check("parity_err", parity_err, exp_vld && q_bad[0]);
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d, input logic [LANES-1:0] be);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = ADDR_W'(a); byteenable = be; writedata = d;
    cyc(); idle();
  endtask

  task automatic do_read(input string name, input int a, input logic [DATA_W-1:0] exp,
                         input bit exp_perr = 1'b0);
    bit got = 1'b0;
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = ADDR_W'(a);
    cyc(); idle();
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (readdatavalid) begin
        got = 1'b1;
        check(name, readdata, exp);
        check({name, "_perr"}, parity_err, exp_perr);
      end
      @(posedge clk); #1;
    end
    if (!got) check({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit rec_vld [7];
    logic [DATA_W-1:0] rec_data [7];

    idle();
    repeat (3) cyc();
    reset_n = 1'b1;

    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!waitrequest) break;
      cnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("fill_cycles", cnt, DEPTH);
    check("init_done_after_fill", init_done, 1);

    for (int a = 0; a < DEPTH; a++) do_read("zero_fill", a, 32'h0);

    do_write(5, 32'hDEADBEEF, 4'b1111);
    do_write(5, 32'h000000AA, 4'b0001);
    do_read("byte_merge", 5, 32'hDEADBEAA);
    do_write(5, 32'hFFFFFFFF, 4'b0000);
    do_read("be_zero_noop", 5, 32'hDEADBEAA);

    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 5'd6; byteenable = 4'hF; writedata = 32'h12345678;
    cyc(); idle();
    repeat (4) begin
      @(negedge clk); check("rw_no_valid", readdatavalid, 0);
      @(posedge clk); #1;
    end
    do_read("rw_write_done", 6, 32'h12345678);

    do_write(7, 32'hCAFEF00D, 4'hF);
    do_read("read_after_write", 7, 32'hCAFEF00D);

    for (int i = 0; i < 4; i++) do_write(i, 32'hA000_0000 + i, 4'hF);
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin chipselect = 1'b1; read = 1'b1; address = ADDR_W'(k); end
      else idle();
      @(negedge clk);
      rec_vld[k] = readdatavalid; rec_data[k] = readdata;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 7; k++) begin
      check("b2b_valid", rec_vld[k], (k >= 2 && k <= 5));
      if (k >= 2 && k <= 5) check("b2b_data", rec_data[k], 32'hA000_0000 + k - 2);
    end

    do_write(4, 32'h0444_4444, 4'hF);
    do_write(20, 32'hFFFFFFFF, 4'hF);
    do_read("oor_read", 20, 32'h0);
    do_read("oor_no_alias", 4, 32'h0444_4444);
    do_read("oor_top", 31, 32'h0);

    chipselect = 1'b1; read = 1'b1; address = 5'd5;
    cyc(); idle(); clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); check("frozen_no_valid", readdatavalid, 0);
      @(posedge clk); #1;
    end
    clken = 1'b1;
    @(negedge clk); check("thaw_not_yet", readdatavalid, 0);
    @(posedge clk); #1;
    @(negedge clk); check("thaw_valid", readdatavalid, 1); check("thaw_data", readdata, 32'hDEADBEAA);
    @(posedge clk); #1;

`ifdef RAM_PARITY_EN
    dut.mem[5][16] = ~dut.mem[5][16];
    m_mem[5][16] = ~m_mem[5][16];
    m_bad[5][2] = 1'b1;
    do_read("parity_flip", 5, 32'hDEACBEAA, 1'b1);
    do_read("parity_clean", 6, 32'h12345678, 1'b0);
`endif

    for (int n = 0; n < 3000; n++) begin
      clken      = ($urandom_range(0, 9) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read       = 1'($urandom_range(0, 1));
      write      = ($urandom_range(0, 2) == 0);
      address    = ADDR_W'($urandom_range(0, 31));
      byteenable = LANES'($urandom);
      writedata  = $urandom;
      cyc();
    end
    idle(); clken = 1'b1;
    repeat (4) cyc();

    reset_n = 1'b0; repeat (2) cyc(); reset_n = 1'b1;
    repeat (7) cyc();
    check("midfill_busy", waitrequest, 1);
    reset_n = 1'b0; repeat (2) cyc(); reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      clken = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (init_done) break;
      if (clken) cnt++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    clken = 1'b1;
    check("refill_enabled_cycles", cnt, DEPTH);
    for (int a = 0; a < DEPTH; a++) do_read("refill_zero", a, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
